fwd_hazard_scb: RTL and testbench
=================================

# fwd_hazard_scb

Parametrised forwarding and load-use hazard unit for the pipelined CPU, successor to the fixed two-stage forwarding unit. It keeps its own scoreboard of in-flight destination registers for DEPTH post-EX stages and registers the ID-stage source addresses into EX. Per EX source operand it drives a forwarding select, and it raises a load-use stall toward the PC/IF-ID/ID-EX control. It sits beside the ID/EX pipeline register and is advanced by the same clock, hold and flush as the datapath.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- DEPTH, 2, post-EX stages that can forward (stage 1 = MEM … stage DEPTH = WB); DEPTH ≥ 2
- CNT_W, 16, stall counter width
- SEL_W (localparam), clog2(DEPTH+1)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active high
- hold_i  in  1  external pipeline freeze (all state holds)
- flush_i  in  1  branch taken: ID instruction is discarded
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  NUM_SRC*ADDR_W  ID source addresses, operand j at [j*ADDR_W +: ADDR_W]
- id_rd_i  in  ADDR_W  ID destination
- id_regwrite_i  in  1  ID instruction writes rd
- id_is_load_i  in  1  ID instruction is a load
- fwd_sel_o  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from stage k
- stall_o  out  1  load-use stall request
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- State: entry e in 0..DEPTH (0 = EX), each {valid, rd, regwrite, is_load}, plus ex_rs (NUM_SRC addresses belonging to entry 0).
- Advance (hold_i=0): entry e ← entry e−1 for e ≥ 1.
- Entry 0 ← ID fields and ex_rs ← id_rs_i when id_valid_i=1 and stall_o=0 and flush_i=0; otherwise entry 0 ← bubble (valid=0, regwrite=0, ex_rs=0).
- Hold (hold_i=1): every entry, ex_rs and stall_cnt_o keep their values; hold has priority over flush and stall.
- An entry is a writer iff valid=1, regwrite=1 and rd≠0. Register 0 is never forwarded and never stalls.
- fwd_sel for operand j: the smallest k in 1..DEPTH such that entry k is a writer and entry k.rd = ex_rs[j]. The youngest writer wins; with no match, 0.
- A load is forwardable only from stage k ≥ 2. A matching load in stage 1 cannot arise while stall_o works; the bench asserts this never occurs.
- stall_o = id_valid_i & ~flush_i & entry 0 is a writer & entry0.is_load & (entry0.rd equals any id_rs_i[j]).
- stall_cnt_o increments on every clock with stall_o=1 and hold_i=0, and saturates at 2^CNT_W−1.

## Timing
- Reset (async, immediate): all entries invalid, ex_rs=0, stall_cnt_o=0. Therefore fwd_sel_o=0 and stall_o=0 while rst_i=1 and after release until new state loads.
- fwd_sel_o is a pure function of registered state and is valid the whole cycle after an edge; there is no combinational path from inputs.
- stall_o is combinational from id_* and entry 0, with zero latency, and must be sampled at the same edge.
- Load-use: exactly one bubble per load (stall_o is high for 1 cycle, absent hold). The consumer then reaches EX with the load in stage 2, so fwd_sel = 2.
- Reset asserted mid-stall drops stall_o within the same cycle. Reset asserted during hold clears state regardless of hold.
- flush_i and stall_o in the same cycle: stall_o is 0 (flush masks it) and a bubble enters.

## Test plan
- Reset: assert rst_i mid-stream -> fwd_sel_o=0, stall_o=0, stall_cnt_o=0 immediately. State holds 0 until the first valid issue.
- Back-to-back ALU: add x5; sub uses x5 next cycle -> fwd_sel=1; one instruction later -> 2; after DEPTH+1 cycles -> 0.
- Youngest wins: add x7, then addi x7, then consumer of x7 on both operands -> both operand sels =1, not 2.
- Load-use: lw x3; add x4,x3,x3 -> stall_o=1 for exactly one cycle, stall_cnt_o=1, then fwd_sel={2,2}. For lw x0, or lw x3 followed by a flush, there is no stall.
- Hold: hold_i=1 for 3 cycles with a pending stall -> state, fwd_sel_o and stall_cnt_o frozen. On release the behaviour is identical to the no-hold case.
- Saturation/params: CNT_W=2 with 5 load-use stalls -> stall_cnt_o=3. With DEPTH=3 and NUM_SRC=3, a write to x9 seen from stages 1..3 -> sels 1,2,3 in turn, and 0 after.

Source files
------------

// File: rtl/fwd_hazard_scb.sv
// rtl/fwd_hazard_scb.sv - forwarding select and load-use stall unit with in-flight destination scoreboard
//
// Tracks the destination of the instruction in EX (entry 0) and in the DEPTH
// post-EX stages (entry 1 = MEM ... entry DEPTH = WB). The source addresses of
// the EX instruction are registered alongside entry 0.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   hold_i         pipeline freeze; all state holds
//   flush_i        ID instruction is discarded (a bubble enters EX)
//   id_valid_i     ID stage holds a real instruction
//   id_rs_i        ID source addresses, operand j at [j*ADDR_W +: ADDR_W]
//   id_rd_i        ID destination register
//   id_regwrite_i  ID instruction writes rd
//   id_is_load_i   ID instruction is a load
//   fwd_sel_o      per EX operand: 0 = register file, k = forward from stage k
//   stall_o        load-use stall request (combinational from ID and entry 0)
//   stall_cnt_o    saturating count of stall cycles
module fwd_hazard_scb #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_is_load_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic              valid_q    [0:DEPTH];
  logic [ADDR_W-1:0] rd_q       [0:DEPTH];
  logic              regwrite_q [0:DEPTH];
  logic              is_load_q  [0:DEPTH];
  logic [ADDR_W-1:0] ex_rs_q    [NUM_SRC];

  logic [DEPTH:0] writer;
  logic           use_hit;
  logic           issue;

  // Register 0 is hard-wired, so an entry targeting it never counts as a writer.
  always_comb begin
    writer = '0;
    for (int e = 0; e <= DEPTH; e++) begin
      writer[e] = valid_q[e] & regwrite_q[e] & (rd_q[e] != '0);
    end
  end

  // Scan from the oldest stage toward the youngest so the youngest match wins.
  always_comb begin
    fwd_sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (writer[k] && (rd_q[k] == ex_rs_q[j])) begin
          fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    use_hit = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (id_rs_i[j*ADDR_W +: ADDR_W] == rd_q[0]) begin
        use_hit = 1'b1;
      end
    end
  end

  // A load in EX cannot forward to the very next instruction; flush masks the
  // request because the consumer in ID is being discarded anyway.
  assign stall_o = id_valid_i & ~flush_i & writer[0] & is_load_q[0] & use_hit;
  assign issue   = id_valid_i & ~stall_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e <= DEPTH; e++) begin
        valid_q[e]    <= 1'b0;
        rd_q[e]       <= '0;
        regwrite_q[e] <= 1'b0;
        is_load_q[e]  <= 1'b0;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
        ex_rs_q[j] <= '0;
      end
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      for (int e = 1; e <= DEPTH; e++) begin
        valid_q[e]    <= valid_q[e-1];
        rd_q[e]       <= rd_q[e-1];
        regwrite_q[e] <= regwrite_q[e-1];
        is_load_q[e]  <= is_load_q[e-1];
      end
      if (issue) begin
        valid_q[0]    <= 1'b1;
        rd_q[0]       <= id_rd_i;
        regwrite_q[0] <= id_regwrite_i;
        is_load_q[0]  <= id_is_load_i;
        for (int j = 0; j < NUM_SRC; j++) begin
          ex_rs_q[j] <= id_rs_i[j*ADDR_W +: ADDR_W];
        end
      end else begin
        valid_q[0]    <= 1'b0;
        rd_q[0]       <= '0;
        regwrite_q[0] <= 1'b0;
        is_load_q[0]  <= 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
          ex_rs_q[j] <= '0;
        end
      end
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scb.sv
// tb/tb_fwd_hazard_scb.sv - directed table-driven bench for fwd_hazard_scb
module tb_fwd_hazard_scb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [14:0] id_rs = '0;
  logic [4:0]  id_rd = '0;
  logic        id_regwrite = 1'b0;
  logic        id_is_load = 1'b0;

  logic [3:0]  fwd_sel_a;
  logic        stall_a;
  logic [15:0] cnt_a;
  logic [5:0]  fwd_sel_b;
  logic        stall_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  fwd_hazard_scb u_a (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs_i(id_rs[9:0]), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .fwd_sel_o(fwd_sel_a), .stall_o(stall_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_scb #(.ADDR_W(5), .NUM_SRC(3), .DEPTH(3), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .fwd_sel_o(fwd_sel_b), .stall_o(stall_b), .stall_cnt_o(cnt_b)
  );

  typedef struct {
    int v, rs0, rs1, rd, rw, ld, fl;
    int s0, s1, st, cnt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rs0, input int rs1, input int rs2,
                       input int rd, input int rw, input int ld, input int fl, input int hd);
    id_valid    = v[0];
    id_rs       = {5'(rs2), 5'(rs1), 5'(rs0)};
    id_rd       = 5'(rd);
    id_regwrite = rw[0];
    id_is_load  = ld[0];
    flush       = fl[0];
    hold        = hd[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int s0, input int s1, input int st, input int cnt);
    chk({nm, " a.sel0"}, int'(fwd_sel_a[1:0]), s0);
    chk({nm, " a.sel1"}, int'(fwd_sel_a[3:2]), s1);
    chk({nm, " a.stall"}, int'(stall_a), st);
    chk({nm, " a.cnt"}, int'(cnt_a), cnt);
  endtask

  task automatic chk_b(input string nm, input int s, input int st, input int cnt);
    chk({nm, " b.sel0"}, int'(fwd_sel_b[1:0]), s);
    chk({nm, " b.sel1"}, int'(fwd_sel_b[3:2]), s);
    chk({nm, " b.sel2"}, int'(fwd_sel_b[5:4]), s);
    chk({nm, " b.stall"}, int'(stall_b), st);
    chk({nm, " b.cnt"}, int'(cnt_b), cnt);
  endtask

  // A matching load must never sit in stage 1 while the stall logic works.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (u_a.valid_q[1] && u_a.regwrite_q[1] && u_a.is_load_q[1] &&
            (u_a.rd_q[1] != 5'd0) && (u_a.rd_q[1] == u_a.ex_rs_q[j])) begin
          errors++;
          $display("FAIL load_in_mem_match: actual operand %0d matches load rd %0d required no match",
                   j, u_a.rd_q[1]);
        end
      end
    end
  end

  initial begin
    //        v rs0 rs1 rd rw ld fl   s0 s1 st cnt
    tbl = '{
      '{1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0},   // add x5
      '{1, 5, 6, 8, 1, 0, 0,  0, 0, 0, 0},   // sub uses x5
      '{1, 6, 5, 0, 1, 0, 0,  1, 0, 0, 0},   // sub sees x5 in stage 1
      '{1, 5, 5, 0, 0, 0, 0,  0, 2, 0, 0},   // x5 seen from stage 2
      '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0},   // x5 producer retired
      '{1, 1, 2, 7, 1, 0, 0,  0, 0, 0, 0},   // add x7
      '{1, 3, 0, 7, 1, 0, 0,  0, 0, 0, 0},   // addi x7
      '{1, 7, 7, 10, 1, 0, 0, 0, 0, 0, 0},   // consumer of x7
      '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0},   // youngest writer wins
      '{1, 2, 0, 3, 1, 1, 0,  0, 0, 0, 0},   // lw x3
      '{1, 3, 3, 4, 1, 0, 0,  0, 0, 1, 0},   // add x4,x3,x3 -> stall
      '{1, 3, 3, 4, 1, 0, 0,  0, 0, 0, 1},   // replayed after bubble
      '{0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 1},   // load forwarded from stage 2
      '{1, 1, 0, 0, 1, 1, 0,  0, 0, 0, 1},   // lw x0
      '{1, 0, 0, 6, 1, 0, 0,  0, 0, 0, 1},   // consumer of x0: no stall
      '{1, 2, 0, 3, 1, 1, 0,  0, 0, 0, 1},   // lw x3
      '{1, 3, 1, 4, 1, 0, 1,  0, 0, 0, 1},   // consumer flushed: no stall
      '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1}
    };

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_a("reset", 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0);
    rst = 1'b0;
    tick();
    mon_on = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].rs0, tbl[i].rs1, 0, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].fl, 0);
      #1;
      chk_a($sformatf("row%0d", i), tbl[i].s0, tbl[i].s1, tbl[i].st, tbl[i].cnt);
      tick();
    end

    // Hold for three cycles with a load-use stall pending.
    drive(1, 0, 0, 0, 3, 1, 1, 0, 0);
    #1; chk_a("hold lw", 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 0, 0, 4, 1, 0, 0, 1);
      #1; chk_a($sformatf("hold%0d", i), 0, 0, 1, 1);
      tick();
    end
    drive(1, 3, 0, 0, 4, 1, 0, 0, 0);
    #1; chk_a("hold release", 0, 0, 1, 1);
    tick();
    #1; chk_a("hold bubble", 0, 0, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1; chk_a("hold fwd", 2, 0, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk_a("hold fwd frozen", 2, 0, 0, 2);
    tick();

    // Reset asserted mid-stall and during hold.
    drive(1, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    drive(1, 3, 0, 0, 4, 1, 0, 0, 0);
    #1; chk_a("pre-reset stall", 0, 0, 1, 2);
    hold = 1'b1;
    rst  = 1'b1;
    #1;
    chk_a("reset mid-stall", 0, 0, 0, 0);
    chk_b("reset mid-stall", 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk_a("post-reset", 0, 0, 0, 0);
    tick();
    #1; chk_a("post-reset idle", 0, 0, 0, 0);

    // x9 walking through DEPTH=3 stages on three operands.
    drive(1, 1, 2, 3, 9, 1, 0, 0, 0);
    #1; chk_b("x9 issue", 0, 0, 0);
    tick();
    drive(1, 9, 9, 9, 0, 0, 0, 0, 0);
    #1; chk_b("x9 c0", 0, 0, 0);
    tick();
    #1; chk_b("x9 stage1", 1, 0, 0); chk_a("x9 stage1", 1, 1, 0, 0);
    tick();
    #1; chk_b("x9 stage2", 2, 0, 0); chk_a("x9 stage2", 2, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk_b("x9 stage3", 3, 0, 0); chk_a("x9 gone", 0, 0, 0, 0);
    tick();
    #1; chk_b("x9 gone", 0, 0, 0);
    tick();

    // Five load-use stalls: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 3, 3, 4, 1, 0, 0, 0);
      #1;
      chk($sformatf("sat%0d a.stall", i), int'(stall_a), 1);
      chk($sformatf("sat%0d b.stall", i), int'(stall_b), 1);
      tick();
      #1;
      chk($sformatf("sat%0d bubble a.stall", i), int'(stall_a), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat a.cnt", int'(cnt_a), 5);
    chk("sat b.cnt", int'(cnt_b), 3);
    tick();

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
